// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: forwarding encodings,
// freeze FSM states and the in-flight scoreboard slot layout.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
  } slot_t;

  // EX additionally remembers its own operands so forwarding can be resolved there.
  typedef struct packed {
    slot_t             prod;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } ex_slot_t;

  // Youngest producer wins; a load still in MEM has no data to forward yet.
  function automatic fwd_sel_t fwd_pick(input logic use_src,
                                        input logic mem_hit,
                                        input logic mem_load,
                                        input logic wb_hit);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_src && mem_hit && !mem_load) begin
      sel = FWD_MEM;
    end else if (use_src && wb_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Producer/source compare: a slot supplies a register only when it is live,
// writes back, and targets a non-zero register equal to the source.
module hazard_slot_match
  import hazard_ctrl_pkg::*;
(
  input  logic              i_valid,
  input  logic              i_wen,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [REG_AW-1:0] i_src,
  output logic              o_match
);

  assign o_match = i_valid & i_wen & (i_rd != '0) & (i_rd == i_src);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I hart: operand forwarding, load-use
// stall, redirect flush, data-memory freeze and hazard performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_wen,
  input  logic              i_id_load,
  input  logic              i_ex_redirect,
  input  logic              i_mem_busy,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_pipe_en,
  output logic [1:0]        o_fwd_rs1,
  output logic [1:0]        o_fwd_rs2,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt,
  output logic [CNT_W-1:0]  o_freeze_cnt
);

  state_t           state_q, state_d;
  ex_slot_t         ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  logic mem_hit_rs1_c, mem_hit_rs2_c, wb_hit_rs1_c, wb_hit_rs2_c;
  logic ex_hit_rs1_c, ex_hit_rs2_c;
  logic load_use_c, redirect_c;
  logic stall_apply_c, flush_apply_c;
  fwd_sel_t fwd_rs1_c, fwd_rs2_c;
  logic unused_wb_load;

  assign unused_wb_load = wb_q.load;

  // Forwarding sources for the instruction currently in EX.
  hazard_slot_match u_mem_rs1 (
    .i_valid (mem_q.valid), .i_wen (mem_q.wen), .i_rd (mem_q.rd),
    .i_src   (ex_q.rs1),    .o_match (mem_hit_rs1_c)
  );
  hazard_slot_match u_mem_rs2 (
    .i_valid (mem_q.valid), .i_wen (mem_q.wen), .i_rd (mem_q.rd),
    .i_src   (ex_q.rs2),    .o_match (mem_hit_rs2_c)
  );
  hazard_slot_match u_wb_rs1 (
    .i_valid (wb_q.valid),  .i_wen (wb_q.wen),  .i_rd (wb_q.rd),
    .i_src   (ex_q.rs1),    .o_match (wb_hit_rs1_c)
  );
  hazard_slot_match u_wb_rs2 (
    .i_valid (wb_q.valid),  .i_wen (wb_q.wen),  .i_rd (wb_q.rd),
    .i_src   (ex_q.rs2),    .o_match (wb_hit_rs2_c)
  );

  // ID sources against the EX producer, for load-use detection.
  hazard_slot_match u_ex_rs1 (
    .i_valid (ex_q.prod.valid), .i_wen (ex_q.prod.wen), .i_rd (ex_q.prod.rd),
    .i_src   (i_id_rs1),        .o_match (ex_hit_rs1_c)
  );
  hazard_slot_match u_ex_rs2 (
    .i_valid (ex_q.prod.valid), .i_wen (ex_q.prod.wen), .i_rd (ex_q.prod.rd),
    .i_src   (i_id_rs2),        .o_match (ex_hit_rs2_c)
  );

  assign load_use_c = i_id_valid & ex_q.prod.load &
                      ((i_id_use_rs1 & ex_hit_rs1_c) | (i_id_use_rs2 & ex_hit_rs2_c));
  assign redirect_c = i_ex_redirect & ex_q.prod.valid;

  always_comb begin
    fwd_rs1_c = fwd_pick(ex_q.use_rs1, mem_hit_rs1_c, mem_q.load, wb_hit_rs1_c);
    fwd_rs2_c = fwd_pick(ex_q.use_rs2, mem_hit_rs2_c, mem_q.load, wb_hit_rs2_c);
  end

  assign o_fwd_rs1 = fwd_rs1_c;
  assign o_fwd_rs2 = fwd_rs2_c;

  // Freeze FSM and pipeline control; busy masks redirect and load-use so they
  // are re-evaluated against unchanged EX contents once memory is ready.
  always_comb begin
    state_d       = state_q;
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_pipe_en     = 1'b1;
    stall_apply_c = 1'b0;
    flush_apply_c = 1'b0;

    case (state_q)
      RUN:     if (i_mem_busy)  state_d = FREEZE;
      FREEZE:  if (!i_mem_busy) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (i_mem_busy) begin
      o_pc_en   = 1'b0;
      o_ifid_en = 1'b0;
      o_pipe_en = 1'b0;
    end else if (redirect_c) begin
      // The ID instruction is on the wrong path, so any stall it needs is moot.
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
      flush_apply_c = 1'b1;
    end else if (load_use_c) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_bubble = 1'b1;
      stall_apply_c = 1'b1;
    end
  end

  // Scoreboard advance mirrors the ID/EX, EX/MEM and MEM/WB registers.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (o_pipe_en) begin
      ex_d.prod.valid = i_id_valid & ~o_idex_bubble;
      ex_d.prod.rd    = i_id_rd;
      ex_d.prod.wen   = i_id_wen;
      ex_d.prod.load  = i_id_load;
      ex_d.rs1        = i_id_rs1;
      ex_d.rs2        = i_id_rs2;
      ex_d.use_rs1    = i_id_use_rs1;
      ex_d.use_rs2    = i_id_use_rs2;
      mem_d           = ex_q.prod;
      wb_d            = mem_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  // Performance counters wrap naturally at 2^CNT_W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (stall_apply_c) stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
      if (flush_apply_c) flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
      if (i_mem_busy)    freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
    end
  end

  assign o_stall_cnt  = stall_cnt_q;
  assign o_flush_cnt  = flush_cnt_q;
  assign o_freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, x0, redirect and freeze
// scenarios with hand-derived expectations.
module tb_hazard_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_id_valid;
  logic [4:0]  i_id_rs1, i_id_rs2, i_id_rd;
  logic        i_id_use_rs1, i_id_use_rs2, i_id_wen, i_id_load;
  logic        i_ex_redirect, i_mem_busy;
  logic        o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_pipe_en;
  logic [1:0]  o_fwd_rs1, o_fwd_rs2;
  logic [31:0] o_stall_cnt, o_flush_cnt, o_freeze_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_id_valid    (i_id_valid),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_id_rd       (i_id_rd),
    .i_id_wen      (i_id_wen),
    .i_id_load     (i_id_load),
    .i_ex_redirect (i_ex_redirect),
    .i_mem_busy    (i_mem_busy),
    .o_pc_en       (o_pc_en),
    .o_ifid_en     (o_ifid_en),
    .o_ifid_flush  (o_ifid_flush),
    .o_idex_bubble (o_idex_bubble),
    .o_pipe_en     (o_pipe_en),
    .o_fwd_rs1     (o_fwd_rs1),
    .o_fwd_rs2     (o_fwd_rs2),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt),
    .o_freeze_cnt  (o_freeze_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld);
    i_id_valid = v; i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_use_rs1 = u1;
    i_id_use_rs2 = u2; i_id_rd = rd; i_id_wen = wen; i_id_load = ld;
  endtask

  task automatic idle_id();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_ex_redirect = 1'b0; i_mem_busy = 1'b0;
    idle_id();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (o_pc_en !== 1'b1) begin errors++; $display("FAIL rst pc_en got %0b exp 1", o_pc_en); end
    checks++; if (o_ifid_en !== 1'b1) begin errors++; $display("FAIL rst ifid_en got %0b exp 1", o_ifid_en); end
    checks++; if (o_ifid_flush !== 1'b0) begin errors++; $display("FAIL rst flush got %0b exp 0", o_ifid_flush); end
    checks++; if (o_idex_bubble !== 1'b0) begin errors++; $display("FAIL rst bubble got %0b exp 0", o_idex_bubble); end
    checks++; if (o_pipe_en !== 1'b1) begin errors++; $display("FAIL rst pipe_en got %0b exp 1", o_pipe_en); end
    checks++; if ({o_fwd_rs1, o_fwd_rs2} !== 4'b0000) begin errors++; $display("FAIL rst fwd got %b%b exp 0000", o_fwd_rs1, o_fwd_rs2); end
    checks++; if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0 || o_freeze_cnt !== 32'd0) begin
      errors++; $display("FAIL rst cnts got %0d/%0d/%0d exp 0/0/0", o_stall_cnt, o_flush_cnt, o_freeze_cnt); end
  endtask

  // add x5,x1,x2 ; add x6,x5,x1
  task automatic test_fwd_mem();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    checks++; if (o_pc_en !== 1'b1 || o_idex_bubble !== 1'b0) begin
      errors++; $display("FAIL fwd_mem nostall pc_en/bubble got %0b/%0b exp 1/0", o_pc_en, o_idex_bubble); end
    step();
    idle_id();
    #1;
    checks++; if (o_fwd_rs1 !== 2'b01) begin errors++; $display("FAIL fwd_mem rs1 got %b exp 01", o_fwd_rs1); end
    checks++; if (o_fwd_rs2 !== 2'b00) begin errors++; $display("FAIL fwd_mem rs2 got %b exp 00", o_fwd_rs2); end
    checks++; if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0 || o_freeze_cnt !== 32'd0) begin
      errors++; $display("FAIL fwd_mem cnts got %0d/%0d/%0d exp 0/0/0", o_stall_cnt, o_flush_cnt, o_freeze_cnt); end
  endtask

  // lw x5,0(x1) ; add x6,x5,x1
  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    checks++; if ({o_pc_en, o_ifid_en, o_idex_bubble, o_ifid_flush} !== 4'b0010) begin
      errors++; $display("FAIL ld_use stall pc/ifid/bub/flush got %b exp 0010", {o_pc_en, o_ifid_en, o_idex_bubble, o_ifid_flush}); end
    step();
    #1;
    checks++; if (o_stall_cnt !== 32'd1) begin errors++; $display("FAIL ld_use stall_cnt got %0d exp 1", o_stall_cnt); end
    checks++; if ({o_pc_en, o_ifid_en, o_idex_bubble} !== 3'b110) begin
      errors++; $display("FAIL ld_use single pc/ifid/bub got %b exp 110", {o_pc_en, o_ifid_en, o_idex_bubble}); end
    step();
    idle_id();
    #1;
    checks++; if (o_fwd_rs1 !== 2'b10) begin errors++; $display("FAIL ld_use fwd_rs1 got %b exp 10", o_fwd_rs1); end
    checks++; if (o_stall_cnt !== 32'd1) begin errors++; $display("FAIL ld_use stall_cnt2 got %0d exp 1", o_stall_cnt); end
  endtask

  // addi x0 ; add x6,x0,x0 ; then lw x0 ; add x6,x0,x0
  task automatic test_x0();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    #1;
    checks++; if ({o_fwd_rs1, o_fwd_rs2} !== 4'b0000) begin errors++; $display("FAIL x0 fwd got %b%b exp 0000", o_fwd_rs1, o_fwd_rs2); end
    step();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    checks++; if (o_idex_bubble !== 1'b0 || o_pc_en !== 1'b1) begin
      errors++; $display("FAIL x0 lw_nostall bubble/pc got %0b/%0b exp 0/1", o_idex_bubble, o_pc_en); end
    step();
    idle_id();
    #1;
    checks++; if (o_stall_cnt !== 32'd0) begin errors++; $display("FAIL x0 stall_cnt got %0d exp 0", o_stall_cnt); end
  endtask

  // add x7 (older) ; add x7 (younger) ; add x8,x1,x7
  task automatic test_mem_priority();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    idle_id();
    #1;
    checks++; if (o_fwd_rs2 !== 2'b01) begin errors++; $display("FAIL mem_prio fwd_rs2 got %b exp 01", o_fwd_rs2); end
    checks++; if (o_fwd_rs1 !== 2'b00) begin errors++; $display("FAIL mem_prio fwd_rs1 got %b exp 00", o_fwd_rs1); end
  endtask

  task automatic test_redirect();
    // Redirect while EX holds a load and ID depends on it: redirect wins.
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    i_ex_redirect = 1'b1;
    #1;
    checks++; if ({o_ifid_flush, o_idex_bubble, o_pc_en, o_ifid_en} !== 4'b1111) begin
      errors++; $display("FAIL redir_ld flush/bub/pc/ifid got %b exp 1111", {o_ifid_flush, o_idex_bubble, o_pc_en, o_ifid_en}); end
    step();
    idle_id();
    #1;
    checks++; if (o_ifid_flush !== 1'b0) begin errors++; $display("FAIL redir_ld ex_invalid flush got %0b exp 0", o_ifid_flush); end
    checks++; if (o_flush_cnt !== 32'd1 || o_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL redir_ld cnts flush/stall got %0d/%0d exp 1/0", o_flush_cnt, o_stall_cnt); end
    i_ex_redirect = 1'b0;

    // Taken branch in EX while ID depends on a load now in MEM.
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    i_ex_redirect = 1'b1;
    #1;
    checks++; if ({o_ifid_flush, o_idex_bubble, o_pc_en} !== 3'b111) begin
      errors++; $display("FAIL redir_br flush/bub/pc got %b exp 111", {o_ifid_flush, o_idex_bubble, o_pc_en}); end
    step();
    i_ex_redirect = 1'b0;
    idle_id();
    #1;
    checks++; if (o_flush_cnt !== 32'd1 || o_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL redir_br cnts flush/stall got %0d/%0d exp 1/0", o_flush_cnt, o_stall_cnt); end
  endtask

  task automatic test_freeze_and_async_reset();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    idle_id();
    i_ex_redirect = 1'b1;
    i_mem_busy    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({o_pipe_en, o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble} !== 5'b00000) begin
        errors++; $display("FAIL freeze cyc%0d pipe/pc/ifid/flush/bub got %b exp 00000", c,
                           {o_pipe_en, o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble}); end
      step();
    end
    i_mem_busy = 1'b0;
    #1;
    checks++; if (o_freeze_cnt !== 32'd3) begin errors++; $display("FAIL freeze cnt got %0d exp 3", o_freeze_cnt); end
    checks++; if ({o_ifid_flush, o_idex_bubble, o_pipe_en} !== 3'b111) begin
      errors++; $display("FAIL freeze release flush/bub/pipe got %b exp 111", {o_ifid_flush, o_idex_bubble, o_pipe_en}); end
    step();
    i_ex_redirect = 1'b0;
    // Build a forwarding case, then pull reset between clock edges.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    step();
    idle_id();
    #1;
    checks++; if (o_fwd_rs1 !== 2'b01 || o_flush_cnt !== 32'd1) begin
      errors++; $display("FAIL pre_rst fwd_rs1/flush_cnt got %b/%0d exp 01/1", o_fwd_rs1, o_flush_cnt); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0 || o_freeze_cnt !== 32'd0) begin
      errors++; $display("FAIL async_rst cnts got %0d/%0d/%0d exp 0/0/0", o_stall_cnt, o_flush_cnt, o_freeze_cnt); end
    checks++; if ({o_fwd_rs1, o_fwd_rs2, o_pc_en, o_pipe_en} !== 6'b000011) begin
      errors++; $display("FAIL async_rst fwd/pc/pipe got %b exp 000011", {o_fwd_rs1, o_fwd_rs2, o_pc_en, o_pipe_en}); end
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_ex_redirect = 1'b0;
    i_mem_busy = 1'b0;
    idle_id();
    test_reset();
    test_fwd_mem();
    test_load_use();
    test_x0();
    test_mem_priority();
    test_redirect();
    test_freeze_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I hart: IF, ID, EX (execute_phase), MEM, WB.
- Tracks destination registers of in-flight instructions in EX, MEM and WB.
- Drives forwarding selects for EX ALU operands and generates stall, bubble and flush controls for load-use, taken branch/jump redirect and data-memory wait.
- Keeps hazard performance counters.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 32, performance counter width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1  in  REG_AW  ID source register 1
- i_id_rs2  in  REG_AW  ID source register 2
- i_id_use_rs1  in  1  ID instruction reads rs1
- i_id_use_rs2  in  1  ID instruction reads rs2
- i_id_rd  in  REG_AW  ID destination register
- i_id_wen  in  1  ID instruction writes rd
- i_id_load  in  1  ID instruction is a load
- i_ex_redirect  in  1  EX pc_out differs from pc+4 (taken branch, jal, jalr)
- i_mem_busy  in  1  data memory not ready; pipeline must hold
- o_pc_en  out  1  PC register load enable
- o_ifid_en  out  1  IF/ID register enable
- o_ifid_flush  out  1  IF/ID becomes NOP
- o_idex_bubble  out  1  ID/EX loads NOP instead of ID contents
- o_pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers
- o_fwd_rs1  out  2  EX op1 source: 00 regfile, 01 EX/MEM result, 10 MEM/WB writeback data
- o_fwd_rs2  out  2  same for op2
- o_stall_cnt  out  CNT_W  cycles with a load-use stall
- o_flush_cnt  out  CNT_W  redirects taken
- o_freeze_cnt  out  CNT_W  cycles frozen by i_mem_busy

Behaviour:
- Internal scoreboard: three slots, EX, MEM and WB. Each slot holds {valid, rd, wen, load}. The EX slot also holds rs1/rs2 and their use flags.
- Slot advance each cycle when o_pipe_en=1:
  - EX <- ID fields, valid = i_id_valid & ~bubble.
  - MEM <- EX.
  - WB <- MEM.
- When o_pipe_en=0, all slots hold.
- Reset: all slot valids 0, counters 0, state RUN.
- Combinational outputs with empty scoreboard: pc_en=1, ifid_en=1, flush=0, bubble=0, pipe_en=1, fwd=00.
- Match definition: a producer slot matches a source register when the slot is valid, wen=1, rd!=0 and rd equals the source.
  - x0 is never forwarded and never causes a stall.
- Forwarding, computed for the EX slot operands:
  - MEM match and MEM.load=0 -> 01.
  - Else WB match -> 10.
  - Else 00.
  - MEM has priority over WB (youngest producer wins).
  - A load in MEM is never forwarded from 01; the load-use stall guarantees this case does not occur.
- Load-use: hazard when i_id_valid, EX.valid, EX.load, EX.wen, EX.rd!=0, and (use_rs1 & rs1==EX.rd or use_rs2 & rs2==EX.rd).
  - Response: pc_en=0, ifid_en=0, idex_bubble=1, for exactly one cycle.
  - On the next cycle the load is in MEM and the consumer forwards from WB.
- Redirect: when i_ex_redirect & EX.valid, then o_ifid_flush=1, o_idex_bubble=1, pc_en=1, and the next EX slot is invalid.
  - Redirect overrides a simultaneous load-use stall; the stalled instruction is on the wrong path.
- FSM:
  - States: RUN, FREEZE.
  - RUN -> FREEZE when i_mem_busy=1.
  - FREEZE -> RUN when i_mem_busy=0.
  - While i_mem_busy=1 (either state): pc_en=0, ifid_en=0, pipe_en=0, bubble=0, flush=0. Redirect and load-use are not acted on.
  - Redirect and load-use are re-evaluated when busy drops; the EX contents are unchanged.
- Counters:
  - stall_cnt increments on each cycle a load-use stall is applied.
  - flush_cnt increments on each cycle a redirect is applied.
  - freeze_cnt increments on each i_mem_busy cycle.
  - All counters wrap modulo 2^CNT_W.
- Asynchronous reset mid-operation clears the scoreboard and counters immediately; outputs return to the empty-scoreboard values.

Decomposition:
- Shared package holds:
  - fwd_sel_t encodings FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - state_t {RUN, FREEZE};
  - slot struct {valid, rd, wen, load}.
- One sub-module, hazard_slot_match: combinational valid/wen/nonzero/equal compare, instantiated once per source/producer pair.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back -> fwd_rs1=01 in the cycle the consumer is in EX; no stall; all counters stay 0.
- lw x5 then add x6,x5,x1 -> one cycle with pc_en=0, ifid_en=0, bubble=1, stall_cnt=1; the next EX cycle has fwd_rs1=10.
- addi x0 then add x6,x0,x0 -> fwd=00, no stall.
- Older add x7 in WB and younger add x7 in MEM, consumer reads x7 -> fwd_rs2=01 (MEM wins).
- lw x5 in EX with i_ex_redirect=1 asserted for an EX branch, and a dependent ID instruction -> flush=1, bubble=1, pc_en=1, flush_cnt=1, stall_cnt=0.
  - This combination is impossible as given (EX holds only one instruction). The combination actually exercised: a taken branch in EX while ID depends on a load in MEM, giving flush=1, bubble=1, pc_en=1, flush_cnt=1, stall_cnt=0.
- i_mem_busy high 3 cycles during a pending redirect -> pipe_en=0 for 3 cycles, freeze_cnt=3; flush asserts on the first cycle busy=0. Then assert i_rst_n=0 mid-run -> counters 0 and fwd=00 asynchronously.
